// File: rtl/mac_accumulator.sv
// Multiply-accumulate controller driving an external combinational N x N multiplier.
// Define MAC_SATURATE_EN to clamp the accumulator on overflow instead of wrapping.
module mac_accumulator #(
  parameter int N     = 4,
  parameter int M     = 8,
  parameter int ACC_W = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_a,
  input  logic [N-1:0]     in_b,
  output logic [N-1:0]     mul_a,
  output logic [N-1:0]     mul_b,
  input  logic [M-1:0]     mul_prod,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             busy,
  output logic             ovf
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] len_r, acc_cnt, add_cnt;
  logic [ACC_W-1:0] acc, acc_add;
  logic [ACC_W:0]   sum_wide;
  logic             p_vld, accept, carry, add_last;

  // One extra bit catches the carry out of the accumulator.
  assign sum_wide = {1'b0, acc} + {{(ACC_W + 1 - M){1'b0}}, mul_prod};
  assign carry    = sum_wide[ACC_W];

`ifdef MAC_SATURATE_EN
  assign acc_add = carry ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
`else
  assign acc_add = sum_wide[ACC_W-1:0];
`endif

  assign accept   = in_valid & in_ready;
  assign add_last = p_vld && (({1'b0, add_cnt} + 1'b1) == {1'b0, len_r});

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = (len != '0) ? ACCUM : DONE;
      end
      ACCUM: begin
        busy     = 1'b1;
        in_ready = (acc_cnt < len_r);
        if (add_last) state_next = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_a   <= '0;
      mul_b   <= '0;
      len_r   <= '0;
      acc     <= '0;
      acc_cnt <= '0;
      add_cnt <= '0;
      out_acc <= '0;
      ovf     <= 1'b0;
      p_vld   <= 1'b0;
    end else begin
      // Operand stage: accept only happens in ACCUM because in_ready is gated by state.
      p_vld <= accept;
      if (accept) begin
        mul_a   <= in_a;
        mul_b   <= in_b;
        acc_cnt <= acc_cnt + 1'b1;
      end
      case (state)
        IDLE: begin
          if (start) begin
            len_r   <= len;
            acc     <= '0;
            ovf     <= 1'b0;
            acc_cnt <= '0;
            add_cnt <= '0;
            if (len == '0) out_acc <= '0;
          end
        end
        ACCUM: begin
          // Add stage: consumes the product of the pair registered on the previous edge.
          if (p_vld) begin
            acc     <= acc_add;
            add_cnt <= add_cnt + 1'b1;
            if (carry) ovf <= 1'b1;
            if (add_last) out_acc <= acc_add;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed bench for mac_accumulator with a behavioural multiplier and a result scoreboard.
module tb_mac_accumulator;
  localparam int N = 4, M = 8, AW = 10, CW = 4;

  logic          clk = 1'b0;
  logic          rst_n, start, in_valid, out_ready;
  logic [CW-1:0] len;
  logic [N-1:0]  in_a, in_b, mul_a, mul_b;
  logic [M-1:0]  mul_prod;
  logic          in_ready, out_valid, busy, ovf;
  logic [AW-1:0] out_acc;

  int checks = 0;
  int errors = 0;
  int model_sum, model_ovf, last_exp;
  int exp_acc_q[$];
  int exp_ovf_q[$];

  always #5 clk = ~clk;
  assign mul_prod = {4'b0, mul_a} * {4'b0, mul_b};

  mac_accumulator #(.N(N), .M(M), .ACC_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mul_a(mul_a), .mul_b(mul_b), .mul_prod(mul_prod),
    .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc),
    .busy(busy), .ovf(ovf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic start_run(input int l);
    start = 1'b1;
    len   = CW'(l);
    tick();
    start     = 1'b0;
    model_sum = 0;
    model_ovf = 0;
  endtask

  task automatic feed(input int a, input int b);
    int n = 0;
    in_valid = 1'b1;
    in_a     = N'(a);
    in_b     = N'(b);
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    chk("feed_ready", 32'(in_ready), 1);
    tick();
    model_sum += a * b;
    if (model_sum > (1 << AW) - 1) begin
      model_ovf = 1;
`ifdef MAC_SATURATE_EN
      model_sum = (1 << AW) - 1;
`else
      model_sum -= (1 << AW);
`endif
    end
    $display("accept a=%0d b=%0d model_sum=%0d", a, b, model_sum);
  endtask

  task automatic push_expected();
    exp_acc_q.push_back(model_sum);
    exp_ovf_q.push_back(model_ovf);
  endtask

  task automatic wait_result(input string tag);
    int n = 0;
    int ea, eo;
    while (!out_valid && n < 10) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, 32'(out_valid), 1);
    ea = (exp_acc_q.size() != 0) ? exp_acc_q.pop_front() : -1;
    eo = (exp_ovf_q.size() != 0) ? exp_ovf_q.pop_front() : -1;
    last_exp = ea;
    chk({tag, "_acc"}, 32'(out_acc), ea);
    chk({tag, "_ovf"}, 32'(ovf), eo);
    $display("result %s out_acc=%0d ovf=%0d", tag, out_acc, ovf);
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_hs_valid"}, 32'(out_valid), 0);
    chk({tag, "_hs_busy"}, 32'(busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0;
    in_a = '0; in_b = '0; out_ready = 1'b0;
    model_sum = 0; model_ovf = 0; last_exp = 0;
    tick();
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_ready", 32'(in_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_acc", 32'(out_acc), 0);
    @(negedge clk) rst_n = 1'b1;
    tick();

    // Reset in the middle of a run.
    start_run(4);
    feed(3, 5);
    feed(2, 2);
    in_valid = 1'b0;
    chk("mid_busy", 32'(busy), 1);
    chk("mid_mul_a", 32'(mul_a), 2);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_mul_a", 32'(mul_a), 0);
    chk("arst_ready", 32'(in_ready), 0);
    chk("arst_valid", 32'(out_valid), 0);
    @(negedge clk) rst_n = 1'b1;
    tick();

    // Back-to-back run of three pairs.
    start_run(3);
    chk("b2b_ready0", 32'(in_ready), 1);
    feed(3, 5);
    feed(15, 15);
    feed(7, 2);
    in_valid = 1'b0;
    push_expected();
    chk("b2b_ready_fall", 32'(in_ready), 0);
    chk("b2b_valid_early", 32'(out_valid), 0);
    tick();
    chk("b2b_valid_lat", 32'(out_valid), 1);
    wait_result("b2b");
    handshake("b2b");

    // Gapped input and back-pressured output.
    start_run(2);
    feed(6, 7);
    in_valid = 1'b0;
    tick();
    tick();
    feed(9, 4);
    in_valid = 1'b0;
    push_expected();
    wait_result("gap");
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("gap_hold_valid", 32'(out_valid), 1);
      chk("gap_hold_acc", 32'(out_acc), last_exp);
    end
    handshake("gap");

    // Zero-length run.
    start_run(0);
    chk("len0_ready", 32'(in_ready), 0);
    chk("len0_valid", 32'(out_valid), 1);
    push_expected();
    wait_result("len0");
    handshake("len0");

    // Overflow run, then start pulsed while in DONE.
    start_run(5);
    for (int i = 0; i < 5; i++) feed(15, 15);
    in_valid = 1'b0;
    push_expected();
    wait_result("ovf");
    start = 1'b1;
    len   = 4'd1;
    tick();
    start = 1'b0;
    chk("done_start_valid", 32'(out_valid), 1);
    chk("done_start_acc", 32'(out_acc), last_exp);
    chk("done_start_ovf", 32'(ovf), 1);
    handshake("ovf");

    // Fresh run clears ovf; start pulsed during ACCUM is ignored.
    start_run(2);
    chk("fresh_ovf_clr", 32'(ovf), 0);
    feed(5, 5);
    in_valid = 1'b0;
    start = 1'b1;
    len   = 4'd7;
    tick();
    start = 1'b0;
    feed(4, 3);
    in_valid = 1'b0;
    push_expected();
    wait_result("accum_start");
    handshake("accum_start");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
